// File: rtl/uart_pkg.sv
// Shared definitions for the board's ASCII UART link: character codes,
// receiver/parser state encodings and bit-period arithmetic.
package uart_pkg;

  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  typedef enum logic [2:0] {P_IDLE, P_A, P_C, P_COLON, P_DIGIT, P_DISCARD} p_state_e;

  // Clock cycles per UART bit; clk_fre is in MHz.
  function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                             input int unsigned rate);
    return (clk_fre * 1000000) / rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 8N1, LSB first, 2-FF synchronised input,
// start-bit glitch rejection and centre sampling of every bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned UART_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned CYCLE = calc_cycle(CLK_FRE, UART_RATE);
  localparam int unsigned HALF  = CYCLE / 2;
  localparam int unsigned CW    = $clog2(CYCLE + 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          fall;

  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (fall) state_q <= START;
        end
        START: begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CW'(CYCLE - 1)) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          // Leave at the stop-bit centre so a back-to-back start edge is seen.
          if (cnt_q == CW'(CYCLE - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (sync2_q) begin
              rx_valid <= 1'b1;
              rx_data  <= shift_q;
            end else begin
              rx_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: parses "DAC:ddd\n" lines from the UART and
// presents a validated 8-bit DAC code with a one-cycle update strobe.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned UART_RATE  = 115200,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] dac_data,
  output logic       dac_valid,
  output logic       cmd_err,
  output logic       frame_err
);

  localparam int unsigned NDW = $clog2(MAX_DIGITS + 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_err;

  uart_rx #(
    .CLK_FRE  (CLK_FRE),
    .UART_RATE(UART_RATE)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_pin  (uart_rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  assign frame_err = rx_err;

  p_state_e       state_q;
  logic [9:0]     acc_q, acc_d;
  logic [NDW-1:0] ndig_q;
  logic           err_pend_q;
  logic           is_digit, ndig_full;

  always_comb begin
    is_digit  = (rx_data >= CH_0) && (rx_data <= CH_9);
    ndig_full = (ndig_q == NDW'(MAX_DIGITS));
    acc_d     = acc_q * 10'd10 + {2'b00, rx_data - CH_0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= P_IDLE;
      acc_q      <= '0;
      ndig_q     <= '0;
      err_pend_q <= 1'b0;
      dac_data   <= '0;
      dac_valid  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      dac_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (rx_err) begin
        if (state_q != P_IDLE) begin
          state_q    <= P_DISCARD;
          err_pend_q <= 1'b1;
        end
      end else if (rx_valid) begin
        case (state_q)
          P_IDLE: begin
            if (rx_data == CH_D) begin
              state_q <= P_A;
            end else if (rx_data != CH_LF && rx_data != CH_CR) begin
              state_q    <= P_DISCARD;
              err_pend_q <= 1'b1;
            end
          end
          P_A: begin
            state_q    <= (rx_data == CH_A) ? P_C : P_DISCARD;
            err_pend_q <= (rx_data != CH_A);
          end
          P_C: begin
            state_q    <= (rx_data == CH_C) ? P_COLON : P_DISCARD;
            err_pend_q <= (rx_data != CH_C);
          end
          P_COLON: begin
            state_q    <= (rx_data == CH_COLON) ? P_DIGIT : P_DISCARD;
            err_pend_q <= (rx_data != CH_COLON);
            acc_q      <= '0;
            ndig_q     <= '0;
          end
          P_DIGIT: begin
            if (is_digit) begin
              if (ndig_full) begin
                state_q    <= P_DISCARD;
                err_pend_q <= 1'b1;
              end else begin
                acc_q  <= acc_d;
                ndig_q <= ndig_q + NDW'(1);
              end
            end else if (rx_data == CH_LF) begin
              if (ndig_q != '0 && acc_q <= 10'd255) begin
                dac_data  <= acc_q[7:0];
                dac_valid <= 1'b1;
              end else begin
                cmd_err <= 1'b1;
              end
              state_q <= P_IDLE;
              acc_q   <= '0;
              ndig_q  <= '0;
            end else if (rx_data != CH_CR) begin
              state_q    <= P_DISCARD;
              err_pend_q <= 1'b1;
            end
          end
          P_DISCARD: begin
            if (rx_data == CH_LF) begin
              cmd_err    <= err_pend_q;
              err_pend_q <= 1'b0;
              state_q    <= P_IDLE;
              acc_q      <= '0;
              ndig_q     <= '0;
            end
          end
          default: state_q <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: line-level reference model, per-cycle output
// comparison, directed scenarios and randomised command lines.
module tb_uart_cmd_rx;

  localparam int CYC = 16;  // 50 MHz / 3.125 Mbit/s

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] dac_data;
  logic       dac_valid, cmd_err, frame_err;

  uart_cmd_rx #(
    .CLK_FRE   (50),
    .UART_RATE (3125000),
    .MAX_DIGITS(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .dac_data (dac_data),
    .dac_valid(dac_valid),
    .cmd_err  (cmd_err),
    .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_dac = 0, n_cerr = 0, n_ferr = 0, n_rxv = 0;
  int cyc = 0, last_rxv = -100;
  int model_dac = 0;

  // Reference model: expected line outcomes (-1 = rejected, else code).
  int         exp_q[$];
  int         pend_ferr = 0;
  logic [7:0] line_q[$];
  bit         line_bad = 0;
  string      HDR = "DAC:";

  task automatic check_eq(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit hdr_prefix();
    if (line_q.size() < 1 || line_q.size() > 3) return 0;
    for (int i = 0; i < line_q.size(); i++)
      if (line_q[i] != HDR[i]) return 0;
    return 1;
  endfunction

  function automatic int eval_line();
    int n = 0;
    int val = 0;
    if (line_q.size() < 4) return -1;
    for (int i = 0; i < 4; i++)
      if (line_q[i] != HDR[i]) return -1;
    for (int i = 4; i < line_q.size(); i++) begin
      if (line_q[i] == 8'h0D) continue;
      if (line_q[i] < "0" || line_q[i] > "9") return -1;
      n++;
      if (n > 3) return -1;
      val = val * 10 + int'(line_q[i] - "0");
    end
    if (n == 0 || val > 255) return -1;
    return val;
  endfunction

  task automatic model_feed(input logic [7:0] b, input bit ferr);
    if (ferr) begin
      pend_ferr++;
      if (line_q.size() != 0) line_bad = 1;
    end else if (!(line_q.size() == 0 && (b == 8'h0A || b == 8'h0D))) begin
      if (b != 8'h0A) begin
        line_q.push_back(b);
      end else if (!line_bad && hdr_prefix()) begin
        line_bad = 1;
        line_q.push_back(b);
      end else begin
        exp_q.push_back(line_bad ? -1 : eval_line());
        line_q.delete();
        line_bad = 0;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    line_q.delete();
    line_bad  = 0;
    pend_ferr = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CYC) @(negedge clk);
    end
    uart_rx = !bad_stop;
    repeat (CYC) @(negedge clk);
    uart_rx = 1'b1;
    if (bad_stop) repeat (CYC) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    model_feed(b, bad_stop);
    send_bits(b, bad_stop);
    check_eq("events_due_by_byte_end", exp_q.size() + pend_ferr, 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_line(input string s, input int bad_idx);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], i == bad_idx);
  endtask

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    int head;
    cyc++;
    if (!rst_n) begin
      model_dac = 0;
      check_eq("reset_outputs", int'({dac_data, dac_valid, cmd_err, frame_err}), 0);
    end else begin
      if (dac_valid) begin
        n_dac++;
        head = (exp_q.size() != 0) ? exp_q[0] : -3;
        check_eq("dac_valid_value", int'(dac_data), head);
        check_eq("dac_valid_latency", cyc - last_rxv, 1);
        if (exp_q.size() != 0) begin
          if (head >= 0) model_dac = head;
          void'(exp_q.pop_front());
        end
      end
      if (cmd_err) begin
        n_cerr++;
        head = (exp_q.size() != 0) ? exp_q[0] : -3;
        check_eq("cmd_err_expected", head, -1);
        check_eq("cmd_err_latency", cyc - last_rxv, 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (frame_err) begin
        n_ferr++;
        check_eq("frame_err_expected", int'(pend_ferr > 0), 1);
        if (pend_ferr > 0) pend_ferr--;
      end
      if (dut.u_rx.rx_valid) begin
        n_rxv++;
        last_rxv = cyc;
      end
      check_eq("dac_data", int'(dac_data), model_dac);
    end
  end

  initial begin
    int b_dac, b_cerr, b_ferr, b_rxv;
    logic [7:0] colon;
    string s;

    check_eq("cycle_fn_default", int'(uart_pkg::calc_cycle(50, 115200)), 434);
    repeat (3) @(negedge clk);
    check_eq("reset_state", int'({dac_data, dac_valid, cmd_err, frame_err}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    b_dac = n_dac; b_cerr = n_cerr;
    send_line("DAC:123\n", -1);
    check_eq("cmd123_data", int'(dac_data), 8'h7B);
    check_eq("cmd123_dac_valid_count", n_dac - b_dac, 1);
    check_eq("cmd123_cmd_err_count", n_cerr - b_cerr, 0);

    send_line("DAC:10\n", -1);
    b_dac = n_dac; b_cerr = n_cerr;
    send_line("DAC:256\n", -1);
    check_eq("cmd256_cmd_err_count", n_cerr - b_cerr, 1);
    check_eq("cmd256_dac_valid_count", n_dac - b_dac, 0);
    check_eq("cmd256_data_kept", int'(dac_data), 10);

    b_dac = n_dac; b_cerr = n_cerr;
    send_line("DAX:1\nDAC:7\r\n", -1);
    check_eq("dax_cmd_err_count", n_cerr - b_cerr, 1);
    check_eq("dac7_dac_valid_count", n_dac - b_dac, 1);
    check_eq("dac7_data", int'(dac_data), 7);

    b_dac = n_dac; b_cerr = n_cerr;
    send_line("DAC:\nDAC:0007\nDAC:1a\n", -1);
    check_eq("bad_lines_cmd_err_count", n_cerr - b_cerr, 3);
    check_eq("bad_lines_dac_valid_count", n_dac - b_dac, 0);
    send_line("DAC:9\n", -1);
    send_line("DAC:007\n", -1);
    check_eq("leading_zero_data", int'(dac_data), 7);

    b_ferr = n_ferr; b_cerr = n_cerr; b_dac = n_dac;
    send_line("DAC:42\n", 5);
    check_eq("stopbit_frame_err_count", n_ferr - b_ferr, 1);
    check_eq("stopbit_cmd_err_count", n_cerr - b_cerr, 1);
    check_eq("stopbit_dac_valid_count", n_dac - b_dac, 0);
    check_eq("stopbit_data_kept", int'(dac_data), 7);
    send_line("DAC:42\n", -1);
    check_eq("after_frame_data", int'(dac_data), 42);

    // Reset partway through the data bits of ':'.
    send_line("DAC", -1);
    colon = 8'h3A;
    uart_rx = 1'b0;
    repeat (CYC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = colon[i];
      repeat (CYC) @(negedge clk);
    end
    #5 rst_n = 1'b0;
    #1 check_eq("async_reset_outputs", int'({dac_data, dac_valid, cmd_err, frame_err}), 0);
    model_reset();
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (CYC) @(negedge clk);
    send_line("DAC:200\n", -1);
    check_eq("post_reset_data", int'(dac_data), 200);

    b_ferr = n_ferr; b_rxv = n_rxv;
    uart_rx = 1'b0;
    #100 uart_rx = 1'b1;
    repeat (3 * CYC) @(negedge clk);
    check_eq("glitch_rx_valid_count", n_rxv - b_rxv, 0);
    check_eq("glitch_frame_err_count", n_ferr - b_ferr, 0);

    for (int l = 0; l < 18; l++) begin
      int kind = $urandom_range(0, 7);
      int v = $urandom_range(0, 255);
      int bad = -1;
      case (kind)
        0, 1, 2: s = $sformatf("DAC:%0d\n", v);
        3:       s = $sformatf("DAC:%03d\r\n", v);
        4:       s = $sformatf("DAC:%0d\n", $urandom_range(256, 999));
        5:       s = $sformatf("DAC:%04d\n", v);
        6: begin
          s = $sformatf("DAC:%0d\n", v);
          s.putc($urandom_range(0, s.len() - 2), 8'($urandom_range(1, 127)));
        end
        default: begin
          s = $sformatf("\r\nDAC:%0d\n", v);
          bad = $urandom_range(0, s.len() - 2);
        end
      endcase
      send_line(s, bad);
    end

    send_line("\nDAC:55\n", -1);
    check_eq("final_data", int'(dac_data), 55);
    repeat (2 * CYC) @(negedge clk);
    check_eq("outstanding_line_events", exp_q.size(), 0);
    check_eq("outstanding_frame_errs", pend_ferr, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
